// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch program-counter generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    // Number of always-zero PC bits for a given instruction alignment (2 or 4 bytes).
    function automatic int align_lsb(input int ialign);
        return (ialign == 2) ? 1 : 2;
    endfunction

    localparam int DEF_IALIGN = 4;
    localparam int IALIGN_LSB = align_lsb(DEF_IALIGN);

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer, push overwrites the oldest entry when full.
// Latency: push/pop/flush take effect at the next edge; top/empty are registered state.
// Backpressure: none; a pop on an empty stack is ignored.
//
// Ports: clk, rst_ (async active-low), flush (drop all entries), push/push_addr,
//        pop, top (current top entry), empty (no entries held).
module pc_ras #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic            flush,
    input  logic            push,
    input  logic [XLEN-1:0] push_addr,
    input  logic            pop,
    output logic [XLEN-1:0] top,
    output logic            empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] ent_q [DEPTH];
    logic [XLEN-1:0] ent_d [DEPTH];
    logic [PW-1:0]   top_ptr_q, top_ptr_d, ptr_inc;
    logic [CW-1:0]   count_q, count_d;
    logic            do_pop;

    assign do_pop  = pop && (count_q != '0);
    assign ptr_inc = top_ptr_q + 1'b1;

    always_comb begin
        ent_d     = ent_q;
        top_ptr_d = top_ptr_q;
        count_d   = count_q;
        if (flush) begin
            top_ptr_d = '0;
            count_d   = '0;
        end else if (do_pop && push) begin
            // Pop consumes the old top, the pushed address takes its slot.
            ent_d[top_ptr_q] = push_addr;
        end else if (push) begin
            // Pointer wraps onto the oldest slot once full; count saturates.
            top_ptr_d      = ptr_inc;
            ent_d[ptr_inc] = push_addr;
            if (count_q != CW'(DEPTH)) begin
                count_d = count_q + 1'b1;
            end
        end else if (do_pop) begin
            top_ptr_d = top_ptr_q - 1'b1;
            count_d   = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            top_ptr_q <= '0;
            count_q   <= '0;
        end else begin
            ent_q     <= ent_d;
            top_ptr_q <= top_ptr_d;
            count_q   <= count_d;
        end
    end

    assign top   = ent_q[top_ptr_q];
    assign empty = (count_q == '0);

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: BOOT/RUN/HALT FSM, trap > branch > RAS > sequential next-PC mux.
// Latency: a redirect sampled this cycle shows on fetch_pc the next cycle.
// Backpressure: fetch_pc holds while fetch_valid && !fetch_ready, unless redirected.
//
// Ports: clk, rst_ (async active-low); fetch_valid/fetch_ready/fetch_pc request to imem;
//        trap_valid/trap_pc, br_valid/br_pc redirects; ras_push/ras_push_addr/ras_pop
//        call/return hints; halt_req/resume/halted control; misalign_err one-cycle pulse.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              IALIGN       = 4,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst_,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] fetch_pc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            br_valid,
    input  logic [XLEN-1:0] br_pc,
    input  logic            ras_push,
    input  logic [XLEN-1:0] ras_push_addr,
    input  logic            ras_pop,
    input  logic            halt_req,
    input  logic            resume,
    output logic            halted,
    output logic            misalign_err
);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            fetch_valid_q, fetch_valid_d;
    logic            halted_q, halted_d;
    logic            misalign_err_q, misalign_err_d;

    logic            accepted;
    logic            ras_push_en, ras_pop_en, ras_empty;
    logic [XLEN-1:0] ras_top;

    assign accepted = fetch_valid_q && fetch_ready;

    // A trap freezes the stack (flush only); a branch outranks a return, so the
    // pop is withheld then, while a push alongside a branch still lands.
    assign ras_push_en = ras_push && !trap_valid;
    assign ras_pop_en  = ras_pop && !trap_valid && !br_valid;

    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_      (rst_),
        .flush     (trap_valid),
        .push      (ras_push_en),
        .push_addr (ras_push_addr),
        .pop       (ras_pop_en),
        .top       (ras_top),
        .empty     (ras_empty)
    );

    always_comb begin
        pc_d           = pc_q;
        misalign_err_d = 1'b0;
        if (trap_valid) begin
            pc_d = trap_pc & ~ALIGN_MASK;
        end else if (br_valid) begin
            if ((br_pc & ALIGN_MASK) == '0) begin
                pc_d = br_pc;
            end else begin
                misalign_err_d = 1'b1;
            end
        end else if (ras_pop_en && !ras_empty) begin
            pc_d = ras_top;
        end else if (accepted) begin
            pc_d = pc_q + XLEN'(IALIGN);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            // Only leave RUN once nothing is left hanging on the fetch interface.
            ST_RUN:  if (halt_req && (!fetch_valid_q || fetch_ready)) state_d = ST_HALT;
            ST_HALT: if (resume) state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase
        fetch_valid_d = (state_d == ST_RUN);
        halted_d      = (state_d == ST_HALT);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q        <= ST_BOOT;
            pc_q           <= RESET_VECTOR;
            fetch_valid_q  <= 1'b0;
            halted_q       <= 1'b0;
            misalign_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            fetch_valid_q  <= fetch_valid_d;
            halted_q       <= halted_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    assign fetch_valid  = fetch_valid_q;
    assign fetch_pc     = pc_q;
    assign halted       = halted_q;
    assign misalign_err = misalign_err_q;

endmodule
